// File: rtl/btn_control.sv
// Two-button front end: synchronize, debounce and edge-detect run/dir presses into en/dir levels.
// Define BTN_LONG_PRESS_EN to add a long-hold detector on btn_run that clears en and dir.
module btn_control #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20,
    parameter int unsigned LONG_CYCLES     = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_run,
    input  logic btn_dir,
    output logic en,
    output logic dir,
    output logic run_press,
    output logic dir_press,
    output logic long_press
);

    typedef enum logic {StReleased, StPressed} state_e;

    localparam logic [CNT_W-1:0] DebLast = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    // Index 0 is btn_run, index 1 is btn_dir.
    logic [1:0]       s1_q, s2_q;
    logic [1:0]       deb_q, deb_d;
    logic [1:0]       press_q, press_d;
    logic [CNT_W-1:0] cnt_q [2];
    logic [CNT_W-1:0] cnt_d [2];
    state_e           state_q [2];
    state_e           state_d [2];
    logic             en_q, en_d;
    logic             dir_q, dir_d;
    logic             long_fire;

    always_comb begin
        for (int i = 0; i < 2; i++) begin
            deb_d[i] = deb_q[i];
            cnt_d[i] = '0;
            if (s2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DebLast) begin
                    deb_d[i] = s2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CntOne;
                end
            end
        end
    end

    // Press is taken from the debounced change itself so the pulse and the toggle share one edge.
    always_comb begin
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            press_d[i] = 1'b0;
            unique case (state_q[i])
                StReleased: begin
                    if (deb_d[i] && !deb_q[i]) begin
                        state_d[i] = StPressed;
                        press_d[i] = 1'b1;
                    end
                end
                StPressed: begin
                    if (!deb_d[i] && deb_q[i]) begin
                        state_d[i] = StReleased;
                    end
                end
                default: state_d[i] = StReleased;
            endcase
        end
    end

`ifdef BTN_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LongLast = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LongDone = CNT_W'(LONG_CYCLES);

    logic [CNT_W-1:0] long_cnt_q, long_cnt_d;
    logic             long_press_q;

    // Counter parks at LongDone after firing so a single hold yields one pulse.
    always_comb begin
        long_cnt_d = '0;
        long_fire  = 1'b0;
        if (state_q[0] == StPressed) begin
            if (long_cnt_q == LongLast) begin
                long_fire  = 1'b1;
                long_cnt_d = LongDone;
            end else if (long_cnt_q == LongDone) begin
                long_cnt_d = LongDone;
            end else begin
                long_cnt_d = long_cnt_q + CntOne;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            long_cnt_q   <= '0;
            long_press_q <= 1'b0;
        end else begin
            long_cnt_q   <= long_cnt_d;
            long_press_q <= long_fire;
        end
    end

    assign long_press = long_press_q;
`else
    // LONG_CYCLES has no effect in this build; the term folds to constant 0.
    assign long_fire  = 1'b0 & (LONG_CYCLES == 0);
    assign long_press = 1'b0;
`endif

    always_comb begin
        en_d  = en_q ^ press_d[0];
        dir_d = dir_q ^ press_d[1];
        if (long_fire) begin
            en_d  = 1'b0;
            dir_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= '0;
            s2_q    <= '0;
            deb_q   <= '0;
            press_q <= '0;
            en_q    <= 1'b0;
            dir_q   <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i]   <= '0;
                state_q[i] <= StReleased;
            end
        end else begin
            s1_q    <= {btn_dir, btn_run};
            s2_q    <= s1_q;
            deb_q   <= deb_d;
            press_q <= press_d;
            en_q    <= en_d;
            dir_q   <= dir_d;
            for (int i = 0; i < 2; i++) begin
                cnt_q[i]   <= cnt_d[i];
                state_q[i] <= state_d[i];
            end
        end
    end

    assign en        = en_q;
    assign dir       = dir_q;
    assign run_press = press_q[0];
    assign dir_press = press_q[1];

endmodule

// File: tb/tb_btn_control.sv
// Self-checking bench for btn_control with a window-based behavioural reference model.
module tb_btn_control;

    localparam int unsigned DEB  = 8;
    localparam int unsigned LONG = 20;
    localparam int unsigned CW   = 8;

    logic clk;
    logic rst, btn_run, btn_dir;
    logic en, dir, run_press, dir_press, long_press;

    int checks   = 0;
    int failures = 0;

    // Reference model: last DEB+2 raw samples per button (bit 0 = newest).
    logic [DEB+1:0] hr, hd;
    logic m_deb_run, m_deb_dir, m_en, m_dir, m_rp, m_dp, m_lp;
    int   m_hold;

    btn_control #(
        .DEBOUNCE_CYCLES(DEB),
        .CNT_W          (CW),
        .LONG_CYCLES    (LONG)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .btn_run   (btn_run),
        .btn_dir   (btn_dir),
        .en        (en),
        .dir       (dir),
        .run_press (run_press),
        .dir_press (dir_press),
        .long_press(long_press)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // A debounced level flips once the DEB synchronized samples (2 edges old and older) all differ.
    task automatic model_edge(input logic r, input logic d, input logic rs);
        logic fr, fd, old_run;
        if (rs) begin
            hr = '0; hd = '0;
            m_deb_run = 0; m_deb_dir = 0;
            m_en = 0; m_dir = 0; m_rp = 0; m_dp = 0; m_lp = 0;
            m_hold = 0;
        end else begin
            hr = {hr[DEB:0], r};
            hd = {hd[DEB:0], d};
            fr = (hr[DEB+1:2] == {DEB{~m_deb_run}});
            fd = (hd[DEB+1:2] == {DEB{~m_deb_dir}});
            old_run = m_deb_run;
            if (fr) m_deb_run = ~m_deb_run;
            if (fd) m_deb_dir = ~m_deb_dir;
            m_rp = fr && m_deb_run;
            m_dp = fd && m_deb_dir;
            m_en  = m_en ^ m_rp;
            m_dir = m_dir ^ m_dp;
            m_lp = 0;
`ifdef BTN_LONG_PRESS_EN
            if (old_run) begin
                m_hold++;
                if (m_hold == LONG) begin
                    m_lp = 1; m_en = 0; m_dir = 0;
                end
            end else begin
                m_hold = 0;
            end
`else
            if (old_run) m_hold++; else m_hold = 0;
`endif
        end
    endtask

    task automatic tick(input logic r, input logic d, input logic rs);
        btn_run = r; btn_dir = d; rst = rs;
        @(posedge clk);
        model_edge(r, d, rs);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 4; i++) begin
            tick(1'($urandom % 2), 1'($urandom % 2), 1'b1);
            checks++;
            if ({en, dir, run_press, dir_press, long_press} !== 5'b0) begin
                failures++;
                $display("FAIL reset_outputs: got %b want 00000",
                         {en, dir, run_press, dir_press, long_press});
            end
        end
    endtask

    task automatic test_latency();
        tick(0, 0, 1); tick(0, 0, 0); tick(0, 0, 0);
        for (int k = 0; k < 15; k++) begin
            tick(1, 0, 0);
            checks += 3;
            if ({en, dir, run_press, dir_press, long_press} !== {m_en, m_dir, m_rp, m_dp, m_lp}) begin
                failures++;
                $display("FAIL latency_model k=%0d: got %b want %b", k,
                         {en, dir, run_press, dir_press, long_press}, {m_en, m_dir, m_rp, m_dp, m_lp});
            end
            if (run_press !== (k == 9)) begin
                failures++;
                $display("FAIL latency_run_press k=%0d: got %b want %b", k, run_press, (k == 9));
            end
            if (en !== (k >= 9)) begin
                failures++;
                $display("FAIL latency_en k=%0d: got %b want %b", k, en, (k >= 9));
            end
        end
        for (int k = 0; k < 14; k++) begin
            tick(0, 0, 0);
            checks++;
            if ({en, run_press} !== 2'b10) begin
                failures++;
                $display("FAIL release_no_pulse k=%0d: got en,run_press=%b want 10", k, {en, run_press});
            end
        end
    endtask

    task automatic test_bounce();
        tick(0, 0, 1);
        for (int c = 0; c < 52; c++) begin
            tick(0, (c < 40) ? 1'((c / 3) % 2) : 1'b0, 0);
            checks += 2;
            if ({dir, dir_press} !== 2'b00) begin
                failures++;
                $display("FAIL bounce_dir c=%0d: got dir,dir_press=%b want 00", c, {dir, dir_press});
            end
            if ({en, dir, run_press, dir_press, long_press} !== {m_en, m_dir, m_rp, m_dp, m_lp}) begin
                failures++;
                $display("FAIL bounce_model c=%0d: got %b want %b", c,
                         {en, dir, run_press, dir_press, long_press}, {m_en, m_dir, m_rp, m_dp, m_lp});
            end
        end
    endtask

    task automatic test_simultaneous();
        int rp_at = -1;
        int dp_at = -1;
        tick(0, 0, 1); tick(0, 0, 0);
        for (int k = 0; k < 14; k++) begin
            tick(1, 1, 0);
            if (run_press === 1'b1) rp_at = k;
            if (dir_press === 1'b1) dp_at = k;
            checks++;
            if ({en, dir, run_press, dir_press, long_press} !== {m_en, m_dir, m_rp, m_dp, m_lp}) begin
                failures++;
                $display("FAIL simul_model k=%0d: got %b want %b", k,
                         {en, dir, run_press, dir_press, long_press}, {m_en, m_dir, m_rp, m_dp, m_lp});
            end
        end
        checks += 2;
        if (rp_at != 9 || dp_at != 9) begin
            failures++;
            $display("FAIL simul_pulse_cycle: got run=%0d dir=%0d want 9 and 9", rp_at, dp_at);
        end
        if ({en, dir} !== 2'b11) begin
            failures++;
            $display("FAIL simul_levels: got en,dir=%b want 11", {en, dir});
        end
        for (int k = 0; k < 14; k++) tick(0, 0, 0);
    endtask

    task automatic test_reset_mid();
        tick(0, 0, 1); tick(0, 0, 0); tick(0, 0, 0);
        for (int k = 0; k < 7; k++) tick(1, 0, 0);
        for (int k = 0; k < 3; k++) begin
            tick(1, 0, 1);
            checks++;
            if ({en, run_press} !== 2'b00) begin
                failures++;
                $display("FAIL midreset_quiet k=%0d: got en,run_press=%b want 00", k, {en, run_press});
            end
        end
        for (int k = 0; k < 15; k++) begin
            tick(1, 0, 0);
            checks += 2;
            if (run_press !== (k == 9)) begin
                failures++;
                $display("FAIL midreset_press k=%0d: got %b want %b", k, run_press, (k == 9));
            end
            if ({en, dir, run_press, dir_press, long_press} !== {m_en, m_dir, m_rp, m_dp, m_lp}) begin
                failures++;
                $display("FAIL midreset_model k=%0d: got %b want %b", k,
                         {en, dir, run_press, dir_press, long_press}, {m_en, m_dir, m_rp, m_dp, m_lp});
            end
        end
        for (int k = 0; k < 14; k++) tick(0, 0, 0);
    endtask

    task automatic test_back_to_back();
        int pulses = 0;
        tick(0, 0, 1); tick(0, 0, 0);
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 40; k++) begin
                tick(k < 20, 0, 0);
                if (run_press === 1'b1) pulses++;
                checks++;
                if ({en, dir, run_press, dir_press, long_press} !== {m_en, m_dir, m_rp, m_dp, m_lp}) begin
                    failures++;
                    $display("FAIL b2b_model p=%0d k=%0d: got %b want %b", p, k,
                             {en, dir, run_press, dir_press, long_press},
                             {m_en, m_dir, m_rp, m_dp, m_lp});
                end
            end
        end
        checks += 2;
        if (pulses != 2) begin
            failures++;
            $display("FAIL b2b_pulse_count: got %0d want 2", pulses);
        end
        if (en !== 1'b0) begin
            failures++;
            $display("FAIL b2b_en_final: got %b want 0", en);
        end
    endtask

    task automatic test_random();
        logic r, d;
        int   len;
        tick(0, 0, 1);
        for (int seg = 0; seg < 60; seg++) begin
            r   = 1'($urandom % 2);
            d   = 1'($urandom % 2);
            len = int'($urandom_range(1, 20));
            for (int k = 0; k < len; k++) begin
                tick(r, d, ($urandom % 97) == 0);
                checks++;
                if ({en, dir, run_press, dir_press, long_press} !== {m_en, m_dir, m_rp, m_dp, m_lp}) begin
                    failures++;
                    $display("FAIL random_model seg=%0d k=%0d: got %b want %b", seg, k,
                             {en, dir, run_press, dir_press, long_press},
                             {m_en, m_dir, m_rp, m_dp, m_lp});
                end
            end
        end
    endtask

`ifdef BTN_LONG_PRESS_EN
    task automatic test_long_press();
        int lp_count = 0;
        tick(0, 0, 1); tick(0, 0, 0);
        for (int k = 0; k < 24; k++) tick(0, k < 12, 0);
        for (int k = 0; k < 49; k++) begin
            tick(1, 0, 0);
            if (long_press === 1'b1) lp_count++;
            checks++;
            if ({en, dir, run_press, dir_press, long_press} !== {m_en, m_dir, m_rp, m_dp, m_lp}) begin
                failures++;
                $display("FAIL long_model k=%0d: got %b want %b", k,
                         {en, dir, run_press, dir_press, long_press}, {m_en, m_dir, m_rp, m_dp, m_lp});
            end
        end
        checks += 2;
        if (lp_count != 1) begin
            failures++;
            $display("FAIL long_pulse_count: got %0d want 1", lp_count);
        end
        if ({en, dir} !== 2'b00) begin
            failures++;
            $display("FAIL long_levels: got en,dir=%b want 00", {en, dir});
        end
        for (int k = 0; k < 14; k++) tick(0, 0, 0);
    endtask
`endif

    initial begin
        btn_run = 0; btn_dir = 0; rst = 1;
        model_edge(0, 0, 1);
        test_reset();
        test_latency();
        test_bounce();
        test_simultaneous();
        test_reset_mid();
        test_back_to_back();
`ifdef BTN_LONG_PRESS_EN
        test_long_press();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
